// File: rtl/lcb_pkg.sv
// Shared types and helpers for the LCB frame unpacker.
package lcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_WAIT,
    ST_MODIFY,
    ST_WRITE,
    ST_REL
  } lcb_state_e;

  localparam int DESC_BIT_LSB  = 0;
  localparam int DESC_BIT_W    = 4;
  localparam int DESC_ADDR_LSB = 4;
  localparam int SKIP_CODE     = 15;

  function automatic int frame_bytes(input int groups, input int mpg);
    return groups * (1 + mpg);
  endfunction

  // Analog measures are stored left-shifted by one, zero-extended to the word.
  function automatic logic [31:0] analog_word(input logic [31:0] meas);
    return meas << 1;
  endfunction

endpackage

// File: rtl/lcb_gap_timer.sv
// Inter-byte gap timer: counts enabled idle clocks and pulses timeout at the limit.
module lcb_gap_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign timeout = enable && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (clear || timeout)  cnt <= '0;
    else if (enable)            cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/lcb_frame_unpacker.sv
// Unpacks LCB receiver bytes into measures and writes them to group memory
// via ROM descriptors; adds frame tracking and gap-timeout resynchronisation.
//
// state      | meaning
// IDLE       | wait for a byte; header bytes latch MSBs, data bytes build a measure
// CHECK      | decode descriptor, advance pointer
// RD_WAIT    | contact read-back in flight
// MODIFY     | merge measure LSB into the read-back word
// WRITE      | wren held for WR_HOLD cycles
// REL        | wait for rxValid to drop
module lcb_frame_unpacker #(
  parameter int MEAS_W      = 10,
  parameter int MPG         = 4,
  parameter int GROUPS      = 3,
  parameter int WORD_W      = 12,
  parameter int ADDR_W      = 10,
  parameter int DESC_W      = 15,
  parameter int ROM_DEPTH   = 384,
  parameter int SKIP_CODE   = lcb_pkg::SKIP_CODE,
  parameter int RD_LAT      = 3,
  parameter int WR_HOLD     = 3,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rawData,
  input  logic                         rxValid,
  output logic [$clog2(ROM_DEPTH)-1:0] addrROMaddr,
  input  logic [DESC_W-1:0]            dataROMaddr,
  output logic [WORD_W-1:0]            wrdOut,
  output logic [ADDR_W-1:0]            wrdAddr,
  output logic                         wren,
  input  logic [WORD_W-1:0]            oldWrd,
  output logic [ADDR_W-1:0]            oldWrdAddr,
  output logic                         oldRdEn,
  output logic                         frameDone,
  output logic                         frameErr,
  output logic [7:0]                   errCnt
);
  import lcb_pkg::*;

  localparam int MSB_W       = MEAS_W - 8;
  localparam int FRAME_BYTES = frame_bytes(GROUPS, MPG);
  localparam int PTR_W       = $clog2(ROM_DEPTH);
  localparam int BC_W        = $clog2(FRAME_BYTES);
  localparam int GP_W        = $clog2(MPG + 1);
  localparam int CYC_W       = 4;

  lcb_state_e              state, state_nxt;
  logic [PTR_W-1:0]        ptr, frame_ptr;
  logic [BC_W-1:0]         byte_cnt;
  logic [GP_W-1:0]         grp_pos;
  logic [7:0]              hdr_q;
  logic [MEAS_W-1:0]       meas_q, meas_nxt;
  logic [DESC_W-1:0]       desc_q;
  logic [WORD_W-1:0]       old_q, mod_wrd;
  logic [DESC_BIT_W-1:0]   bit_fld;
  logic [CYC_W-1:0]        cyc_cnt;
  logic                    last_q;
  logic                    take_byte, ptr_inc, rd_done, done_pulse, gap_en, tmo;

  assign addrROMaddr = ptr;
  assign wren        = (state == ST_WRITE);
  assign oldRdEn     = (state == ST_RD_WAIT);
  assign gap_en      = (state == ST_IDLE) && (byte_cnt != '0) && !rxValid;
  assign bit_fld     = desc_q[DESC_BIT_LSB +: DESC_BIT_W];

  always_comb begin
    meas_nxt = {MSB_W'(hdr_q >> (8 - MSB_W * int'(grp_pos))), rawData};
    mod_wrd  = old_q;
    mod_wrd[bit_fld - DESC_BIT_W'(1)] = meas_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_byte  = 1'b0;
    ptr_inc    = 1'b0;
    rd_done    = 1'b0;
    done_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rxValid) begin
          take_byte = 1'b1;
          state_nxt = (grp_pos == '0) ? ST_REL : ST_CHECK;
        end
      end
      ST_CHECK: begin
        ptr_inc = 1'b1;
        if (desc_q == DESC_W'(SKIP_CODE))                     state_nxt = ST_REL;
        else if (desc_q[DESC_W-1])                            state_nxt = ST_WRITE;
        else if ((bit_fld == '0) || (int'(bit_fld) > WORD_W)) state_nxt = ST_REL;
        else                                                  state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cyc_cnt == CYC_W'(RD_LAT - 1)) begin
          rd_done   = 1'b1;
          state_nxt = ST_MODIFY;
        end
      end
      ST_MODIFY: state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (cyc_cnt == CYC_W'(WR_HOLD - 1)) begin
          done_pulse = last_q;
          state_nxt  = ST_REL;
        end
      end
      ST_REL: begin
        if (!rxValid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt    <= '0;
      ptr        <= '0;
      frame_ptr  <= '0;
      byte_cnt   <= '0;
      grp_pos    <= '0;
      hdr_q      <= '0;
      meas_q     <= '0;
      desc_q     <= '0;
      old_q      <= '0;
      last_q     <= 1'b0;
      wrdOut     <= '0;
      wrdAddr    <= '0;
      oldWrdAddr <= '0;
      frameDone  <= 1'b0;
      frameErr   <= 1'b0;
      errCnt     <= '0;
    end else begin
      cyc_cnt <= (state_nxt != state) ? '0 : cyc_cnt + CYC_W'(1);
      if (take_byte) begin
        byte_cnt <= (byte_cnt == BC_W'(FRAME_BYTES - 1)) ? '0 : byte_cnt + BC_W'(1);
        grp_pos  <= (grp_pos == GP_W'(MPG)) ? '0 : grp_pos + GP_W'(1);
        desc_q   <= dataROMaddr;
        last_q   <= (byte_cnt == BC_W'(FRAME_BYTES - 1));
        if (byte_cnt == '0) frame_ptr <= ptr;
        if (grp_pos == '0)  hdr_q     <= rawData;
        else                meas_q    <= meas_nxt;
      end else if (tmo) begin
        // Abort the partial frame and replay its descriptors on the next frame.
        byte_cnt <= '0;
        grp_pos  <= '0;
        ptr      <= frame_ptr;
      end
      if (ptr_inc) ptr <= (ptr == PTR_W'(ROM_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      if (state == ST_CHECK) begin
        wrdOut     <= WORD_W'(analog_word(32'(meas_q)));
        wrdAddr    <= desc_q[DESC_ADDR_LSB +: ADDR_W];
        oldWrdAddr <= desc_q[DESC_ADDR_LSB +: ADDR_W];
      end
      if (rd_done)             old_q  <= oldWrd;
      if (state == ST_MODIFY)  wrdOut <= mod_wrd;
      frameDone <= done_pulse;
      frameErr  <= tmo;
      if (tmo && (errCnt != 8'hFF)) errCnt <= errCnt + 8'd1;
    end
  end

  lcb_gap_timer #(
    .TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (take_byte),
    .enable  (gap_en),
    .timeout (tmo)
  );

endmodule

// File: tb/tb_lcb_frame_unpacker.sv
// Directed bench for lcb_frame_unpacker with ROM, group-memory and read-latency models.
module tb_lcb_frame_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rawData;
  logic        rxValid;
  logic [8:0]  addrROMaddr;
  logic [14:0] dataROMaddr;
  logic [11:0] wrdOut;
  logic [9:0]  wrdAddr;
  logic        wren;
  logic [11:0] oldWrd;
  logic [9:0]  oldWrdAddr;
  logic        oldRdEn;
  logic        frameDone;
  logic        frameErr;
  logic [7:0]  errCnt;

  int total = 0;
  int bad   = 0;

  logic [14:0] rom [0:383];
  logic [11:0] mem [0:1023];
  logic [1:0]  rd_pipe = '0;

  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, ferr_cnt = 0;
  int          wr_len = 0, rd_len = 0, wr_unstable = 0;
  logic [9:0]  wr_addr = '0, rd_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wren_d = 1'b0, rd_d = 1'b0;

  int g1_b [4] = '{'h11, 'h22, 'h33, 'h44};
  int g1_w [4] = '{'h622, 'h444, 'h266, 'h088};
  int g3_w [4] = '{'h100, 'h300, 'h500, 'h700};

  lcb_frame_unpacker dut (
    .clk         (clk),
    .reset       (reset),
    .rawData     (rawData),
    .rxValid     (rxValid),
    .addrROMaddr (addrROMaddr),
    .dataROMaddr (dataROMaddr),
    .wrdOut      (wrdOut),
    .wrdAddr     (wrdAddr),
    .wren        (wren),
    .oldWrd      (oldWrd),
    .oldWrdAddr  (oldWrdAddr),
    .oldRdEn     (oldRdEn),
    .frameDone   (frameDone),
    .frameErr    (frameErr),
    .errCnt      (errCnt)
  );

  always #5 clk = ~clk;

  assign dataROMaddr = rom[addrROMaddr];
  // Read data is only valid once oldRdEn has been high long enough.
  assign oldWrd = rd_pipe[1] ? mem[oldWrdAddr] : 12'hBAD;

  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[0], oldRdEn};
    if (wren) mem[wrdAddr] <= wrdOut;
  end

  always @(negedge clk) begin
    wren_d <= wren;
    rd_d   <= oldRdEn;
    if (wren && !wren_d) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= wrdAddr;
      wr_data <= wrdOut;
      wr_len  <= 1;
    end else if (wren) begin
      wr_len <= wr_len + 1;
    end
    if (wren_d && ((wrdAddr != wr_addr) || (wrdOut != wr_data))) wr_unstable <= wr_unstable + 1;
    if (oldRdEn && !rd_d) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= oldWrdAddr;
      rd_len  <= 1;
    end else if (oldRdEn) begin
      rd_len <= rd_len + 1;
    end
    if (frameDone) done_cnt <= done_cnt + 1;
    if (frameErr)  ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int settle);
    @(negedge clk);
    rawData = b;
    rxValid = 1'b1;
    repeat (hold) @(negedge clk);
    rxValid = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input int cnt0, input int addr, input int data);
    check_val({tag, "_n"}, wr_cnt - cnt0, 1);
    check_val({tag, "_addr"}, wr_addr, addr);
    check_val({tag, "_data"}, wr_data, data);
    check_val({tag, "_len"}, wr_len, 3);
  endtask

  function automatic logic [14:0] rom_analog(input int a);
    return 15'h4000 | 15'(a << 4);
  endfunction

  initial begin
    int c0, r0, n;
    for (int i = 0; i < 384; i++) rom[i] = 15'd15;
    for (int i = 0; i < 1024; i++) mem[i] <= '0;
    mem[20] <= 12'h0F0;
    for (int i = 0; i < 4; i++) rom[i] = rom_analog(5 + i);
    rom[4] = 15'((20 << 4) | 3);
    rom[5] = 15'd15;
    rom[6] = 15'(30 << 4);
    rom[7] = rom_analog(9);
    for (int i = 0; i < 4; i++) rom[8 + i] = rom_analog(10 + i);
    for (int i = 0; i < 12; i++) rom[372 + i] = rom_analog(100 + i);

    reset   = 1'b0;
    rawData = '0;
    rxValid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_wren", wren, 0);
    check_val("rst_rden", oldRdEn, 0);
    check_val("rst_ptr", addrROMaddr, 0);
    check_val("rst_errcnt", errCnt, 0);
    check_val("rst_wrdout", wrdOut, 0);
    check_val("rst_done", frameDone, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1, group 1: analog measures to 5..8
    c0 = wr_cnt;
    send_byte(8'hE4, 1, 3);
    check_val("hdr_no_wr", wr_cnt - c0, 0);
    check_val("hdr_ptr", addrROMaddr, 0);
    for (int i = 0; i < 4; i++) begin
      c0 = wr_cnt;
      send_byte(8'(g1_b[i]), 1, 12);
      expect_write($sformatf("g1_m%0d", i), c0, 5 + i, g1_w[i]);
    end
    check_val("g1_ptr", addrROMaddr, 4);

    // Group 2: contact RMW, skip code, contact with bit field 0, analog
    send_byte(8'h00, 1, 3);
    c0 = wr_cnt;
    r0 = rd_cnt;
    send_byte(8'h01, 1, 14);
    check_val("ct_rd_n", rd_cnt - r0, 1);
    check_val("ct_rd_addr", rd_addr, 20);
    check_val("ct_rd_len", rd_len, 3);
    expect_write("ct", c0, 20, 'h0F4);
    c0 = wr_cnt;
    send_byte(8'h55, 1, 12);
    check_val("skip_no_wr", wr_cnt - c0, 0);
    check_val("skip_ptr", addrROMaddr, 6);
    c0 = wr_cnt;
    r0 = rd_cnt;
    send_byte(8'h66, 1, 12);
    check_val("fld0_no_wr", wr_cnt - c0, 0);
    check_val("fld0_no_rd", rd_cnt - r0, 0);
    check_val("fld0_ptr", addrROMaddr, 7);
    c0 = wr_cnt;
    send_byte(8'h7F, 1, 12);
    expect_write("g2_m3", c0, 9, 'h0FE);

    // Group 3 closes the frame
    send_byte(8'h1B, 1, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_val("done_early", done_cnt, 0);
      c0 = wr_cnt;
      send_byte(8'h80, 1, 12);
      expect_write($sformatf("g3_m%0d", i), c0, 10 + i, g3_w[i]);
    end
    check_val("f1_done", done_cnt, 1);
    check_val("f1_ptr", addrROMaddr, 12);
    check_val("f1_stable", wr_unstable, 0);

    // Skip-only frames walk the pointer to 372
    for (int f = 0; f < 30; f++)
      for (int b = 0; b < 15; b++) send_byte(8'h00, 1, 2);
    check_val("walk_ptr", addrROMaddr, 372);
    check_val("walk_done", done_cnt, 1);

    // Frame spanning the ROM wrap
    for (int g = 0; g < 2; g++) begin
      send_byte(8'h00, 1, 3);
      for (int i = 0; i < 4; i++) send_byte(8'h00, 1, 12);
    end
    check_val("wrap_mid_ptr", addrROMaddr, 380);
    send_byte(8'hFF, 1, 3);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1, 12);
    c0 = wr_cnt;
    send_byte(8'hAB, 1, 12);
    expect_write("wrap_last", c0, 111, 'h756);
    check_val("wrap_ptr", addrROMaddr, 0);
    check_val("wrap_done", done_cnt, 2);

    // Gap timeout after six bytes
    send_byte(8'hE4, 1, 3);
    for (int i = 0; i < 4; i++) send_byte(8'(g1_b[i]), 1, 12);
    send_byte(8'hE4, 1, 3);
    check_val("gap_pre_ptr", addrROMaddr, 4);
    repeat (300) @(negedge clk);
    check_val("gap_ferr", ferr_cnt, 1);
    check_val("gap_errcnt", errCnt, 1);
    check_val("gap_ptr", addrROMaddr, 0);
    check_val("gap_no_done", done_cnt, 2);
    send_byte(8'hC0, 1, 3);
    c0 = wr_cnt;
    send_byte(8'h00, 1, 12);
    expect_write("resync", c0, 5, 'h600);

    // rxValid held high: one byte only
    c0 = wr_cnt;
    send_byte(8'h01, 50, 12);
    expect_write("hold", c0, 6, 'h002);
    check_val("hold_ptr", addrROMaddr, 2);

    // Reset during WRITE
    @(negedge clk);
    rawData = 8'h05;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    n = 0;
    while (!wren && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_wr_seen", wren, 1);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_mid_wren", wren, 0);
    check_val("rst_mid_rden", oldRdEn, 0);
    check_val("rst_mid_ptr", addrROMaddr, 0);
    check_val("rst_mid_errcnt", errCnt, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
